// File: rtl/axi_lite_sram_if.sv
// AXI-Lite AR/R/AW/W/B channel bundle between the bus arbiter (master) and the SRAM slave.
interface axi_lite_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic                  awvalid_i;
  logic                  awready_o;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [STRB_WIDTH-1:0] wstrb_i;
  logic                  wvalid_i;
  logic                  wready_o;
  logic [1:0]            bresp_o;
  logic                  bvalid_o;
  logic                  bready_i;

  modport slave (
    input  araddr_i, arvalid_i, rready_i,
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o,
    output awready_o, wready_o, bresp_o, bvalid_o
  );

  modport master (
    output araddr_i, arvalid_i, rready_i,
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o,
    input  awready_o, wready_o, bresp_o, bvalid_o
  );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI-Lite slave serving a word-addressed SRAM with independent read/write FSMs and programmable latency.
// Optional: define AXI_SRAM_RAND_DELAY_EN to add LFSR jitter (0..7 cycles, saturating at 15) to each latency load.
module axi_lite_sram #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  axi_lite_sram_if.slave bus
);
  localparam int                    IDX_W       = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES   = ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [3:0]            cnt_load;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [4:0] cnt_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_sum  = 5'(LATENCY) + {2'b00, lfsr[2:0]};
  assign cnt_load = (cnt_sum > 5'd15) ? 4'd15 : cnt_sum[3:0];
`else
  assign cnt_load = 4'(LATENCY);
`endif

  // ---------------------------------------------------------------- read path
  r_state_e              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_cnt;
  logic                  r_dec_vld;
  logic                  r_in_range;
  logic [IDX_W-1:0]      r_idx;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    r_state_nxt   = r_state;
    bus.arready_o = 1'b0;
    bus.rvalid_o  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        bus.arready_o = 1'b1;
        if (bus.arvalid_i) r_state_nxt = R_WAIT;
      end
      R_WAIT: if (r_dec_vld && r_cnt == 4'd0) r_state_nxt = R_RESP;
      R_RESP: begin
        bus.rvalid_o = 1'b1;
        if (bus.rready_i) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= R_IDLE;
    else         r_state <= r_state_nxt;
  end

  // The first WAIT cycle registers the address decode; the latency count runs after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_dec_vld   <= 1'b0;
      r_in_range  <= 1'b0;
      r_idx       <= '0;
      bus.rdata_o <= '0;
      bus.rresp_o <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (bus.arvalid_i) begin
          r_addr    <= bus.araddr_i;
          r_cnt     <= cnt_load;
          r_dec_vld <= 1'b0;
        end
        R_WAIT: begin
          if (!r_dec_vld) begin
            r_in_range <= addr_in_range(r_addr);
            r_idx      <= addr_index(r_addr);
            r_dec_vld  <= 1'b1;
          end else if (r_cnt == 4'd0) begin
            bus.rdata_o <= r_in_range ? mem[r_idx] : '0;
            bus.rresp_o <= r_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- write path
  w_state_e              w_state, w_state_nxt;
  logic                  aw_done, w_done;
  logic                  aw_rdy, w_rdy, aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [3:0]            w_cnt;
  logic                  w_dec_vld;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  mem_we;

  always_comb begin
    w_state_nxt  = w_state;
    aw_rdy       = 1'b0;
    w_rdy        = 1'b0;
    bus.bvalid_o = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_rdy = !aw_done;
        w_rdy  = !w_done;
      end
      W_WAIT: if (w_dec_vld && w_cnt == 4'd0) w_state_nxt = W_RESP;
      W_RESP: begin
        bus.bvalid_o = 1'b1;
        if (bus.bready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
    aw_hs = bus.awvalid_i && aw_rdy;
    w_hs  = bus.wvalid_i && w_rdy;
    if (w_state == W_IDLE && (aw_done || aw_hs) && (w_done || w_hs)) w_state_nxt = W_WAIT;
  end

  assign bus.awready_o = aw_rdy;
  assign bus.wready_o  = w_rdy;
  assign mem_we        = (w_state == W_WAIT) && w_dec_vld && (w_cnt == 4'd0) && w_in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) w_state <= W_IDLE;
    else         w_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      w_cnt       <= '0;
      w_dec_vld   <= 1'b0;
      w_in_range  <= 1'b0;
      w_idx       <= '0;
      bus.bresp_o <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_addr  <= bus.awaddr_i;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_data <= bus.wdata_i;
            w_strb <= bus.wstrb_i;
            w_done <= 1'b1;
          end
          // Later non-blocking assignments win, so the completing cycle clears both flags.
          if (w_state_nxt == W_WAIT) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            w_cnt     <= cnt_load;
            w_dec_vld <= 1'b0;
          end
        end
        W_WAIT: begin
          if (!w_dec_vld) begin
            w_in_range <= addr_in_range(w_addr);
            w_idx      <= addr_index(w_addr);
            w_dec_vld  <= 1'b1;
          end else if (w_cnt == 4'd0) begin
            bus.bresp_o <= w_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array is deliberately left out of reset; a reset port would force it into flops instead of SRAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end
endmodule
